// File: rtl/riscv_pkg.sv
// Shared core-level types and widths for the writeback / register-file path.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int unsigned NUM_WB_SRC = 3;

    // Writeback source index; matches the requester slot on the arbiter.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_CSR = 2'd2
    } wb_src_e;

    // One register-file write request.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer with wrap and grants the
// first active request. The pointer moves past the winner on every grant.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_c,
    output logic [$clog2(N)-1:0] gnt_idx_c,
    output logic                 gnt_any_c
);

    localparam int unsigned    IDX_W = $clog2(N);
    localparam logic [IDX_W:0] N_W   = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Priority scan starting at ptr_q, wrapping at N.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = IDX_W'(sum);
            if (!gnt_any_c && req_i[idx]) begin
                gnt_any_c  = 1'b1;
                gnt_idx_c  = idx;
                gnt_c[idx] = 1'b1;
            end
        end
    end

    // Next pointer: one past the winner, held when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any_c) begin
            ptr_d = (gnt_idx_c == LAST) ? '0 : gnt_idx_c + IDX_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among the writeback sources with a
// round-robin valid/ready handshake, registers the selected write, and keeps
// the per-register busy scoreboard used by decode for hazard stalls.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = riscv_pkg::NUM_WB_SRC,
    parameter int unsigned XLEN    = riscv_pkg::XLEN,
    parameter int unsigned ADDR_W  = riscv_pkg::REG_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*XLEN-1:0]    req_data,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [2**ADDR_W-1:0]       busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [XLEN-1:0]    sel_data;

    logic               rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [NREGS-1:0]   busy_q,     busy_d;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .gnt_c     (gnt),
        .gnt_idx_c (gnt_idx),
        .gnt_any_c (gnt_any)
    );

    // No handshake may complete while reset is asserted.
    assign req_ready = gnt & {NUM_REQ{rst_n}};

    // Request mux driven by the one-hot grant.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Write stage next state: x0 grants consume the request but never write.
    always_comb begin
        rf_we_d    = gnt_any && (sel_addr != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        if (gnt_any) begin
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
            grant_id_d = gnt_idx;
        end
    end

    // Scoreboard: retire clears, issue sets afterwards so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: round-robin order, x0 handling,
// scoreboard set/clear priority, same-address ordering, backpressure, reset.
module tb_regfile_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned XL = 32;
    localparam int unsigned AW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*XL-1:0] req_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XL-1:0]   rf_wdata;
    logic [1:0]      grant_id;
    logic [31:0]     busy;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(
        .NUM_REQ (N),
        .XLEN    (XL),
        .ADDR_W  (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XL-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*XL +: XL] = d;
    endtask

    // Requester protocol monitor: a pending request must hold valid/addr/data.
    logic [N-1:0]    pend;
    logic [N*AW-1:0] pa;
    logic [N*XL-1:0] pd;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    assert (req_valid[i] && req_addr[i*AW +: AW] == pa[i*AW +: AW]
                            && req_data[i*XL +: XL] == pd[i*XL +: XL]) else begin
                        failures++;
                        $error("FAIL protocol req%0d dropped or changed before ready", i);
                    end
                end
            end
            pend <= req_valid & ~req_ready;
            pa   <= req_addr;
            pd   <= req_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 3'b111;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we",    32'(rf_we),     32'd0);
        chk("rst_waddr", 32'(rf_waddr),  32'd0);
        chk("rst_wdata", rf_wdata,       32'd0);
        chk("rst_gid",   32'(grant_id),  32'd0);
        chk("rst_busy",  busy,           32'd0);

        // Round-robin with all three requesters active.
        for (int i = 0; i < 3; i++) set_req(i, AW'(i + 1), 32'h1000_0000 + 32'(i));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
            tick();
            if (k >= 3) req_valid[k % 3] = 1'b0;
            chk("rr_we",    32'(rf_we),    32'd1);
            chk("rr_gid",   32'(grant_id), 32'(k % 3));
            chk("rr_waddr", 32'(rf_waddr), 32'((k % 3) + 1));
            chk("rr_wdata", rf_wdata,      32'h1000_0000 + 32'(k % 3));
        end
        tick();
        chk("idle_we",    32'(rf_we),    32'd0);
        chk("idle_waddr", 32'(rf_waddr), 32'd3);
        chk("idle_wdata", rf_wdata,      32'h1000_0002);

        // x0 write: handshake completes, no register write.
        set_req(1, 5'd0, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        chk("x0_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        chk("x0_we", 32'(rf_we), 32'd0);

        // Scoreboard set, set-beats-clear, then clear.
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        issue_valid = 1'b0;
        chk("sb_set", busy, 32'h0000_0020);
        set_req(0, 5'd5, 32'h0000_AAAA);
        req_valid = 3'b001;
        #1;
        chk("sb_ready0", 32'(req_ready), 32'd1);
        tick();
        req_valid   = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        chk("sb_we",    32'(rf_we),    32'd1);
        chk("sb_waddr", 32'(rf_waddr), 32'd5);
        tick();
        issue_valid = 1'b0;
        chk("sb_setwins", busy,        32'h0000_0020);
        chk("sb_we_off",  32'(rf_we),  32'd0);
        set_req(1, 5'd5, 32'h0000_BBBB);
        req_valid = 3'b010;
        #1;
        chk("sb_ready1", 32'(req_ready), 32'd2);
        tick();
        req_valid   = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        chk("sb_we2",  32'(rf_we),    32'd1);
        chk("sb_gid2", 32'(grant_id), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("sb_clear", busy, 32'd0);

        // Same address from req0 and req2; pointer is at 2 so req2 goes first.
        set_req(0, 5'd7, 32'h1);
        set_req(2, 5'd7, 32'h2);
        req_valid = 3'b101;
        #1;
        chk("same_ready_a", 32'(req_ready), 32'd4);
        tick();
        req_valid = 3'b001;
        chk("same_we_a",    32'(rf_we),    32'd1);
        chk("same_gid_a",   32'(grant_id), 32'd2);
        chk("same_wdata_a", rf_wdata,      32'h2);
        #1;
        chk("same_ready_b", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        chk("same_we_b",    32'(rf_we),    32'd1);
        chk("same_waddr_b", 32'(rf_waddr), 32'd7);
        chk("same_final",   rf_wdata,      32'h1);

        // Backpressure: req2 waits while req0/req1 stream; pointer starts at 1.
        set_req(0, 5'd10, 32'h0000_00A0);
        set_req(1, 5'd11, 32'h0000_00A1);
        set_req(2, 5'd9,  32'h0000_000C);
        req_valid = 3'b111;
        #1;
        chk("bp_ready_a", 32'(req_ready), 32'd2);
        tick();
        chk("bp_gid_a",   32'(grant_id),  32'd1);
        chk("bp_ready_b", 32'(req_ready), 32'd4);
        tick();
        req_valid = 3'b011;
        chk("bp_gid_b",   32'(grant_id), 32'd2);
        chk("bp_waddr_b", 32'(rf_waddr), 32'd9);
        chk("bp_wdata_b", rf_wdata,      32'h0000_000C);
        #1;
        chk("bp_ready_c", 32'(req_ready), 32'd1);
        tick();
        chk("bp_ready_d", 32'(req_ready), 32'd2);
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        tick();
        issue_valid = 1'b0;
        chk("pre_rst_busy", busy,       32'h0000_1000);
        chk("pre_rst_we",   32'(rf_we), 32'd1);
        #1;

        // Reset in the middle of traffic.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_we",    32'(rf_we),     32'd0);
        chk("mid_rst_waddr", 32'(rf_waddr),  32'd0);
        chk("mid_rst_wdata", rf_wdata,       32'd0);
        chk("mid_rst_gid",   32'(grant_id),  32'd0);
        chk("mid_rst_busy",  busy,           32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 3'b010;
        chk("rel_we",    32'(rf_we),    32'd1);
        chk("rel_gid",   32'(grant_id), 32'd0);
        chk("rel_waddr", 32'(rf_waddr), 32'd10);
        tick();
        req_valid = '0;
        chk("rel_gid2", 32'(grant_id), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
